// File: rtl/rtmc_spi_cmd.sv
// rtl/rtmc_spi_cmd.sv - SPI opcode/address/data decoder driving a register bus handshake.
// Optional auto-increment bursts are enabled with the RTMC_BURST_EN macro.
module rtmc_spi_cmd #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cs_active,
    input  logic              rx_valid,
    input  logic [7:0]        rx_byte,
    output logic [7:0]        tx_byte,
    output logic [ADDR_W-1:0] reg_addr,
    output logic [DATA_W-1:0] reg_wdata,
    output logic              reg_wr,
    output logic              reg_rd,
    input  logic [DATA_W-1:0] reg_rdata,
    input  logic              reg_ready,
    output logic              busy,
    output logic              err
);
    localparam int ADDR_BYTES = (ADDR_W + 7) / 8;
    localparam int DATA_BYTES = DATA_W / 8;
    localparam int MAX_BYTES  = (ADDR_BYTES > DATA_BYTES) ? ADDR_BYTES : DATA_BYTES;
    localparam int CNT_W      = $clog2(MAX_BYTES + 1);

    localparam logic [CNT_W-1:0] ADDR_LAST = CNT_W'(ADDR_BYTES - 1);
    localparam logic [CNT_W-1:0] DATA_LAST = CNT_W'(DATA_BYTES - 1);
    localparam logic [CNT_W-1:0] DATA_END  = CNT_W'(DATA_BYTES);

    localparam logic [7:0] OP_NOP     = 8'h00;
    localparam logic [7:0] OP_RD      = 8'h01;
    localparam logic [7:0] OP_WR      = 8'h02;
    localparam logic [7:0] R_ACK      = 8'h01;
    localparam logic [7:0] R_ACK_DATA = 8'h02;

    typedef enum logic [3:0] {
        S_IDLE, S_ADDR, S_WDATA, S_WR_BUS, S_WR_ACK, S_RD_BUS,
        S_RD_ACK, S_RDATA, S_DONE, S_DRAIN, S_ABORT
    } state_t;

    state_t            state_q;
    logic [7:0]        tx_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic              wr_q;
    logic              rd_q;
    logic              err_q;
    logic              is_wr_q;
    logic [CNT_W-1:0]  cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            tx_q    <= 8'h00;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            err_q   <= 1'b0;
            is_wr_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            err_q <= 1'b0;
            if (!cs_active && state_q != S_IDLE && state_q != S_ABORT) begin
                // Frame end: an outstanding bus request must still be completed.
                tx_q  <= 8'h00;
                cnt_q <= '0;
                if ((wr_q || rd_q) && !reg_ready) begin
                    state_q <= S_ABORT;
                    err_q   <= 1'b1;
                end else begin
                    wr_q    <= 1'b0;
                    rd_q    <= 1'b0;
                    state_q <= S_IDLE;
                end
            end else begin
                case (state_q)
                    S_IDLE: begin
                        tx_q  <= 8'h00;
                        cnt_q <= '0;
                        if (cs_active && rx_valid) begin
                            if (rx_byte == OP_RD || rx_byte == OP_WR) begin
                                is_wr_q <= (rx_byte == OP_WR);
                                state_q <= S_ADDR;
                            end else begin
                                err_q   <= (rx_byte != OP_NOP);
                                state_q <= S_DRAIN;
                            end
                        end
                    end
                    S_ADDR: if (rx_valid) begin
                        addr_q <= ADDR_W'({addr_q, rx_byte});
                        if (cnt_q == ADDR_LAST) begin
                            cnt_q <= '0;
                            if (is_wr_q) begin
                                state_q <= S_WDATA;
                            end else begin
                                rd_q    <= 1'b1;
                                state_q <= S_RD_BUS;
                            end
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_WDATA: if (rx_valid) begin
                        wdata_q <= DATA_W'({wdata_q, rx_byte});
                        if (cnt_q == DATA_LAST) begin
                            cnt_q   <= '0;
                            wr_q    <= 1'b1;
                            state_q <= S_WR_BUS;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    S_WR_BUS: if (reg_ready) begin
                        wr_q    <= 1'b0;
                        tx_q    <= R_ACK;
                        state_q <= S_WR_ACK;
                    end
                    S_WR_ACK: if (rx_valid) begin
                        tx_q <= 8'h00;
`ifdef RTMC_BURST_EN
                        addr_q  <= addr_q + ADDR_W'(1);
                        cnt_q   <= '0;
                        state_q <= S_WDATA;
`else
                        state_q <= S_DONE;
`endif
                    end
                    S_RD_BUS: if (reg_ready) begin
                        rd_q    <= 1'b0;
                        rdata_q <= reg_rdata;
                        tx_q    <= R_ACK_DATA;
                        state_q <= S_RD_ACK;
                    end
                    S_RD_ACK: if (rx_valid) begin
                        // Read data is streamed MSB first by shifting the captured word.
                        tx_q    <= rdata_q[DATA_W-1 -: 8];
                        rdata_q <= rdata_q << 8;
                        cnt_q   <= CNT_W'(1);
                        state_q <= S_RDATA;
                    end
                    S_RDATA: if (rx_valid) begin
                        if (cnt_q == DATA_END) begin
                            tx_q  <= 8'h00;
                            cnt_q <= '0;
`ifdef RTMC_BURST_EN
                            addr_q  <= addr_q + ADDR_W'(1);
                            rd_q    <= 1'b1;
                            state_q <= S_RD_BUS;
`else
                            state_q <= S_DONE;
`endif
                        end else begin
                            tx_q    <= rdata_q[DATA_W-1 -: 8];
                            rdata_q <= rdata_q << 8;
                            cnt_q   <= cnt_q + 1'b1;
                        end
                    end
                    S_DONE, S_DRAIN: tx_q <= 8'h00;
                    S_ABORT: begin
                        tx_q <= 8'h00;
                        if (rx_valid) begin
                            err_q <= 1'b1;
                        end
                        if (reg_ready) begin
                            wr_q    <= 1'b0;
                            rd_q    <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign tx_byte   = tx_q;
    assign reg_addr  = addr_q;
    assign reg_wdata = wdata_q;
    assign reg_wr    = wr_q;
    assign reg_rd    = rd_q;
    assign err       = err_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_rtmc_spi_cmd.sv
// tb/tb_rtmc_spi_cmd.sv - table-driven bench for rtmc_spi_cmd (default and 12/32-bit instances).
`timescale 1ns/1ps
module tb_rtmc_spi_cmd;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cs = 1'b0;
    logic        cs1 = 1'b0;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_byte = 8'h00;

    logic [7:0]  tx0;
    logic [7:0]  addr0;
    logic [15:0] wdata0;
    logic        wr0, rd0, busy0, err0;
    logic        ready0 = 1'b0;
    logic [15:0] rdata0 = 16'hBEEF;

    logic [7:0]  tx1;
    logic [11:0] addr1;
    logic [31:0] wdata1;
    logic        wr1, rd1, busy1, err1;
    logic        ready1 = 1'b0;
    logic [31:0] rdata1 = 32'h0;

    always #5 clk = ~clk;

    rtmc_spi_cmd u_dut (
        .clk(clk), .rst_n(rst_n), .cs_active(cs), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .tx_byte(tx0), .reg_addr(addr0), .reg_wdata(wdata0), .reg_wr(wr0), .reg_rd(rd0),
        .reg_rdata(rdata0), .reg_ready(ready0), .busy(busy0), .err(err0)
    );

    rtmc_spi_cmd #(.ADDR_W(12), .DATA_W(32)) u_wide (
        .clk(clk), .rst_n(rst_n), .cs_active(cs1), .rx_valid(rx_valid), .rx_byte(rx_byte),
        .tx_byte(tx1), .reg_addr(addr1), .reg_wdata(wdata1), .reg_wr(wr1), .reg_rd(rd1),
        .reg_rdata(rdata1), .reg_ready(ready1), .busy(busy1), .err(err1)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Bus model: answers after ws wait cycles and logs completed transfers.
    int          ws = 0;
    int          bus_cnt = 0;
    int          rd_cycles = 0;
    int          err_count = 0;
    logic [7:0]  wr_addr_log[$];
    logic [15:0] wr_data_log[$];
    logic [7:0]  rd_addr_log[$];
    int          wr1_count = 0;
    logic [11:0] wr1_addr = '0;
    logic [31:0] wr1_data = '0;

    always @(negedge clk) begin
        if (wr0 || rd0) begin
            if (bus_cnt == ws) begin
                ready0 = 1'b1;
                bus_cnt = 0;
                if (wr0) begin
                    wr_addr_log.push_back(addr0);
                    wr_data_log.push_back(wdata0);
                end else begin
                    rd_addr_log.push_back(addr0);
                end
            end else begin
                ready0 = 1'b0;
                bus_cnt++;
            end
        end else begin
            ready0 = 1'b0;
            bus_cnt = 0;
        end
        if (rd0) rd_cycles++;
        if (err0) err_count++;
        ready1 = wr1 | rd1;
        if (wr1) begin
            wr1_count++;
            wr1_addr = addr1;
            wr1_data = wdata1;
        end
    end

    logic [7:0] tx_seen, tx1_seen;

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_valid = 1'b1;
        rx_byte  = b;
        tx_seen  = tx0;
        tx1_seen = tx1;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic end_frame();
        @(negedge clk);
        cs = 1'b0;
        repeat (2) @(negedge clk);
        chk("busy_after_frame", busy0, 1'b0);
    endtask

    typedef struct {
        bit         start;
        int         ws;
        logic [7:0] rx;
        logic [7:0] exp_tx;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input bit start, input int w, input logic [7:0] rx, input logic [7:0] ex);
        vec_t v;
        v.start = start; v.ws = w; v.rx = rx; v.exp_tx = ex;
        tbl.push_back(v);
    endfunction

    task automatic run_table(input int lo, input int hi);
        for (int i = lo; i < hi; i++) begin
            if (tbl[i].start) begin
                end_frame();
                ws = tbl[i].ws;
                @(negedge clk);
                cs = 1'b1;
            end
            send_byte(tbl[i].rx);
            chk($sformatf("tx[%0d]", i), tx_seen, tbl[i].exp_tx);
        end
        end_frame();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int split;
        logic [7:0]  exp_wa[$];
        logic [15:0] exp_wd[$];

        // Write, 0 wait states.
        add(1, 0, 8'h02, 8'h00); add(0, 0, 8'h05, 8'h00); add(0, 0, 8'h12, 8'h00);
        add(0, 0, 8'h34, 8'h00); add(0, 0, 8'h00, 8'h01); add(0, 0, 8'h00, 8'h00);
        // Read, 3 wait states; the second poll coincides with bus completion.
        add(1, 3, 8'h01, 8'h00); add(0, 3, 8'h0A, 8'h00);
        add(0, 3, 8'h00, 8'h00); add(0, 3, 8'h00, 8'h00); add(0, 3, 8'h00, 8'h02);
        add(0, 3, 8'h00, 8'hBE); add(0, 3, 8'h00, 8'hEF); add(0, 3, 8'h00, 8'h00);
        // Unknown opcode drains the frame.
        add(1, 0, 8'h7F, 8'h00); add(0, 0, 8'h11, 8'h00); add(0, 0, 8'h22, 8'h00); add(0, 0, 8'h33, 8'h00);
        // NOP drains without error.
        add(1, 0, 8'h00, 8'h00); add(0, 0, 8'h02, 8'h00); add(0, 0, 8'h05, 8'h00);
        // Write with 2 wait states: first poll still busy.
        add(1, 2, 8'h02, 8'h00); add(0, 2, 8'h40, 8'h00); add(0, 2, 8'hAB, 8'h00); add(0, 2, 8'hCD, 8'h00);
        add(0, 2, 8'h00, 8'h00); add(0, 2, 8'h00, 8'h01); add(0, 2, 8'h00, 8'h00);
        // Write to 0xFF followed by a second word.
        add(1, 0, 8'h02, 8'h00); add(0, 0, 8'hFF, 8'h00); add(0, 0, 8'h11, 8'h00); add(0, 0, 8'h22, 8'h00);
        add(0, 0, 8'h00, 8'h01); add(0, 0, 8'h33, 8'h00); add(0, 0, 8'h44, 8'h00);
`ifdef RTMC_BURST_EN
        add(0, 0, 8'h00, 8'h01); add(0, 0, 8'h00, 8'h00);
`else
        add(0, 0, 8'h00, 8'h00); add(0, 0, 8'h00, 8'h00);
`endif
        split = tbl.size();
        // Normal write after an aborted read.
        add(1, 0, 8'h02, 8'h00); add(0, 0, 8'h77, 8'h00); add(0, 0, 8'h56, 8'h00);
        add(0, 0, 8'h78, 8'h00); add(0, 0, 8'h00, 8'h01); add(0, 0, 8'h00, 8'h00);

        exp_wa = '{8'h05, 8'h40, 8'hFF};
        exp_wd = '{16'h1234, 16'hABCD, 16'h1122};
`ifdef RTMC_BURST_EN
        exp_wa.push_back(8'h00); exp_wd.push_back(16'h3344);
`endif
        exp_wa.push_back(8'h77); exp_wd.push_back(16'h5678);

        repeat (3) @(negedge clk);
        chk("rst_tx", tx0, 8'h00);
        chk("rst_addr", addr0, 8'h00);
        chk("rst_wdata", wdata0, 16'h0000);
        chk("rst_wr", wr0, 1'b0);
        chk("rst_rd", rd0, 1'b0);
        chk("rst_busy", busy0, 1'b0);
        chk("rst_err", err0, 1'b0);
        chk("rst_wide_tx", tx1, 8'h00);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        run_table(0, split);
        chk("err_count_table", err_count, 1);
        chk("rd_cycles_3ws", rd_cycles, 4);

        // cs_active drops while the read request waits 5 cycles for the bus.
        ws = 5;
        @(negedge clk);
        cs = 1'b1;
        send_byte(8'h01);
        send_byte(8'h33);
        @(negedge clk);
        cs = 1'b0;
        @(negedge clk);
        chk("abort_busy_during", busy0, 1'b1);
        chk("abort_rd_held", rd0, 1'b1);
        repeat (10) @(negedge clk);
        chk("abort_busy_after", busy0, 1'b0);
        chk("abort_rd_dropped", rd0, 1'b0);
        chk("abort_err_once", err_count, 2);
        chk("abort_rd_cycles", rd_cycles, 10);

        run_table(split, tbl.size());

        chk("wr_log_size", wr_addr_log.size(), exp_wa.size());
        for (int i = 0; i < exp_wa.size() && i < wr_addr_log.size(); i++) begin
            chk($sformatf("wr_addr[%0d]", i), wr_addr_log[i], exp_wa[i]);
            chk($sformatf("wr_data[%0d]", i), wr_data_log[i], exp_wd[i]);
        end
        chk("rd_log_size", rd_addr_log.size(), 2);
        if (rd_addr_log.size() == 2) begin
            chk("rd_addr0", rd_addr_log[0], 8'h0A);
            chk("rd_addr1", rd_addr_log[1], 8'h33);
        end
        chk("err_count_final", err_count, 2);

        // 12-bit address, 32-bit data instance.
        @(negedge clk);
        cs1 = 1'b1;
        send_byte(8'h02); send_byte(8'h0F); send_byte(8'hFF);
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE); send_byte(8'hEF);
        chk("wide_tx_last_data", tx1_seen, 8'h00);
        send_byte(8'h00);
        chk("wide_tx_ack", tx1_seen, 8'h01);
        send_byte(8'h00);
        chk("wide_tx_after_ack", tx1_seen, 8'h00);
        @(negedge clk);
        cs1 = 1'b0;
        repeat (2) @(negedge clk);
        chk("wide_wr_count", wr1_count, 1);
        chk("wide_addr", wr1_addr, 12'hFFF);
        chk("wide_wdata", wr1_data, 32'hDEADBEEF);
        chk("wide_busy", busy1, 1'b0);
        chk("dut0_untouched", wr_addr_log.size(), exp_wa.size());

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/rtmc_spi_cmd.md
Name: rtmc_spi_cmd

Overview:
- Protocol engine between the SPI byte shifter and the register bus.
- Decodes opcode/address/data byte streams of parametrised width and issues register read/write handshakes with wait-state support.
- Returns BUSY/ACK/ACK_DATA result bytes and read data to the host.
- Generalises the fixed 8-bit-address/16-bit-data SPI RW protocol to arbitrary byte-multiple widths, with optional auto-increment bursts.

Parameters:
- ADDR_W, 8, register address width (1..16); ADDR_BYTES = ceil(ADDR_W/8) bytes are sent MSB first, and the low ADDR_W bits are used.
- DATA_W, 16, register data width; must be a multiple of 8; DATA_BYTES = DATA_W/8 bytes, MSB first.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- cs_active  in  1  chip select asserted, already synchronised to clk.
- rx_valid  in  1  one-cycle pulse: a received byte is complete.
- rx_byte  in  8  received byte; valid with rx_valid.
- tx_byte  out  8  registered; the shifter transmits in the next byte slot the value present in the cycle rx_valid=1.
- reg_addr  out  ADDR_W  bus address.
- reg_wdata  out  DATA_W  bus write data.
- reg_wr  out  1  write request.
- reg_rd  out  1  read request.
- reg_rdata  in  DATA_W  read data, valid with reg_ready during reg_rd.
- reg_ready  in  1  completes the current request.
- busy  out  1  state != IDLE.
- err  out  1  one-cycle pulse on protocol error.

Behaviour:
- Opcodes: NOP=0x00, RD=0x01, WR=0x02. Results: R_BUSY=0x00, R_ACK=0x01, R_ACK_DATA=0x02. Filler byte is 0x00.
- Reset: state IDLE; tx_byte=0x00; reg_addr=0; reg_wdata=0; reg_wr=0; reg_rd=0; busy=0; err=0; counters=0.
- Default: tx_byte=0x00 in every state that is not driving a result or read data.
- Bus handshake:
  - reg_wr/reg_rd are asserted the cycle after the triggering rx_valid.
  - reg_addr/reg_wdata are held stable while a request is asserted.
  - The request completes at the first rising edge with reg_ready=1; zero wait states are legal. The request drops the following cycle.
- States and transitions (on rx_valid unless noted):
  - IDLE: first byte while cs_active.
    - RD or WR -> ADDR.
    - NOP -> DRAIN.
    - Any other value -> DRAIN with err pulse.
  - ADDR: shift ADDR_BYTES bytes into the address.
    - After the last byte: WR -> WDATA; RD -> RD_BUS.
  - WDATA: shift DATA_BYTES bytes into reg_wdata. After the last byte -> WR_BUS.
  - WR_BUS: reg_wr=1. On reg_ready: tx_byte<=R_ACK, -> WR_ACK (no rx_valid needed). Poll bytes return 0x00.
  - WR_ACK: the next rx_valid starts the ACK slot. tx_byte<=0x00, -> DONE.
  - RD_BUS: reg_rd=1. On reg_ready: capture reg_rdata, tx_byte<=R_ACK_DATA, -> RD_ACK.
  - RD_ACK: next rx_valid: tx_byte<=data byte 0 (MSB), -> RDATA.
  - RDATA, index k: next rx_valid: tx_byte<=byte k+1. After the last byte is loaded, the following rx_valid sets tx_byte<=0x00 and -> DONE.
  - DONE / DRAIN: bytes ignored, tx_byte=0x00.
- Frame end: cs_active=0 in any state -> IDLE next cycle, tx_byte<=0x00, partial address/data discarded.
  - Exception: if reg_wr/reg_rd is asserted, go to ABORT. Hold the request until reg_ready, discard the result, then -> IDLE. Raise one err pulse on entering ABORT.
- rx_valid during ABORT: ignored, err pulse.
- rx_valid while cs_active=0: ignored.
- cs_active rising edge: no action; the first rx_valid starts decode.
- rx_valid coincident with reg_ready in WR_BUS/RD_BUS: bus completion wins. The poll slot carries 0x00, and the result appears in the next slot.

Optional Feature:
- Macro: RTMC_BURST_EN.
- Defined:
  - Write bursts: the WR_ACK slot leads to WDATA instead of DONE. The next DATA_BYTES bytes write reg_addr+1.
  - Read bursts: after the last data byte is loaded, -> RD_BUS with reg_addr+1.
  - Address wraps modulo 2^ADDR_W. Frame end terminates the burst.
- Undefined: after one transaction the FSM stays in DONE until cs_active=0.

Test Plan:
- Write, defaults, 0 wait: bytes 02,05,12,34, then 2 polls -> reg_wr one cycle with addr=0x05, wdata=0x1234. The poll slots return 00,01.
- Read with 3 wait states: bytes 01,0A, then 6 polls, reg_rdata=0xBEEF -> slots return 00,00,...,02,BE,EF. reg_rd is held for 4 cycles.
- Unknown opcode 0x7F then 3 bytes -> err pulse once, no bus activity, tx 0x00 throughout.
- cs_active drops during RD_BUS with reg_ready delayed 5 cycles -> err pulse, reg_rd held until ready, busy=0 after, a new frame decodes normally.
- ADDR_W=12, DATA_W=32: bytes 02,0F,FF,DE,AD,BE,EF -> addr=0xFFF, wdata=0xDEADBEEF.
- RTMC_BURST_EN, write to 0xFF (ADDR_W=8) then a second word -> second reg_wr at addr 0x00; without the macro the second word is ignored.
